// File: rtl/mux_8x2.sv
// Dual 4:1 single-bit multiplexer in the style of a 74153, with registered outputs.
// Both channels share one select {selb, sela}. Each channel has its own active-low enable.
// A disabled channel loads 0 on the next edge.
module mux_8x2 (
   input  logic clk,
   input  logic rst,
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   input  logic in4,
   input  logic in5,
   input  logic in6,
   input  logic in7,
   input  logic sela,
   input  logic selb,
   input  logic e1,
   input  logic e2,
   output logic y1,
   output logic y2
);

   logic [1:0] sel;
   logic       nxt_y1;
   logic       nxt_y2;

   assign sel = {selb, sela};

   // Channel 1 next value. The case reads only the selected input,
   // so an X on an unselected input never reaches the register.
   always_comb begin
      nxt_y1 = 1'b0;
      if (!e1) begin
         case (sel)
            2'b00:   nxt_y1 = in0;
            2'b01:   nxt_y1 = in1;
            2'b10:   nxt_y1 = in2;
            2'b11:   nxt_y1 = in3;
            default: nxt_y1 = 1'b0;
         endcase
      end
   end

   // Channel 2 next value. Same select as channel 1, but its own enable.
   always_comb begin
      nxt_y2 = 1'b0;
      if (!e2) begin
         case (sel)
            2'b00:   nxt_y2 = in4;
            2'b01:   nxt_y2 = in5;
            2'b10:   nxt_y2 = in6;
            2'b11:   nxt_y2 = in7;
            default: nxt_y2 = 1'b0;
         endcase
      end
   end

   // Output registers. Synchronous reset takes priority over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         y1 <= 1'b0;
         y2 <= 1'b0;
      end else begin
         y1 <= nxt_y1;
         y2 <= nxt_y2;
      end
   end

endmodule

// File: tb/tb_mux_8x2.sv
// Self-checking bench for mux_8x2.
// It applies a table of vectors, then hand-written latency and reset sequences, then random vectors.
// Expected results go into a queue when stimulus is driven and are compared after the next edge.
module tb_mux_8x2;

   logic clk = 1'b0;
   logic rst;
   logic in0, in1, in2, in3, in4, in5, in6, in7;
   logic sela, selb, e1, e2;
   logic y1, y2;

   typedef struct {
      logic       rst;
      logic [7:0] d;      // {in7..in0}
      logic [1:0] s;      // {selb, sela}
      logic       e1;
      logic       e2;
      logic       y1;
      logic       y2;
      string      name;
   } vec_t;

   typedef struct {
      logic  y1;
      logic  y2;
      string name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   mux_8x2 dut (
      .clk  (clk),
      .rst  (rst),
      .in0  (in0),
      .in1  (in1),
      .in2  (in2),
      .in3  (in3),
      .in4  (in4),
      .in5  (in5),
      .in6  (in6),
      .in7  (in7),
      .sela (sela),
      .selb (selb),
      .e1   (e1),
      .e2   (e2),
      .y1   (y1),
      .y2   (y2)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [1:0] s,
                               input logic en1, input logic en2, input logic ey1,
                               input logic ey2, input string name);
      vec_t v;
      v.rst = r; v.d = d; v.s = s; v.e1 = en1; v.e2 = en2;
      v.y1 = ey1; v.y2 = ey2; v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input logic a1, input logic a2,
                        input logic x1, input logic x2);
      n_vec++;
      if ({a1, a2} !== {x1, x2}) begin
         n_err++;
         $display("FAIL %s: got y1=%b y2=%b, want y1=%b y2=%b", name, a1, a2, x1, x2);
      end
   endtask

   task automatic set_inputs(input vec_t v);
      rst = v.rst;
      {in7, in6, in5, in4, in3, in2, in1, in0} = v.d;
      {selb, sela} = v.s;
      e1 = v.e1;
      e2 = v.e2;
   endtask

   // Drive on the falling edge, push the expectation, then compare just after the rising edge.
   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      set_inputs(v);
      e.y1 = v.y1; e.y2 = v.y2; e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb.pop_front();
         check(e.name, y1, y2, e.y1, e.y2);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] s;
      logic       en1, en2;

      rst = 1'b1;
      {in7, in6, in5, in4, in3, in2, in1, in0} = 8'hFF;
      {selb, sela} = 2'b00;
      e1 = 1'b0;
      e2 = 1'b0;

      // Reset with all data inputs high and both channels enabled.
      vecs.push_back(mk(1, 8'hFF, 2'd0, 0, 0, 0, 0, "reset_edge1"));
      vecs.push_back(mk(1, 8'hFF, 2'd0, 0, 0, 0, 0, "reset_edge2"));
      vecs.push_back(mk(0, 8'hFF, 2'd0, 0, 0, 1, 1, "reset_release"));
      // Select sweep: the selected inputs are in[s]=0 and in[4+s]=1, every other input is the opposite.
      vecs.push_back(mk(0, 8'h1E, 2'd0, 0, 0, 0, 1, "sel_00"));
      vecs.push_back(mk(0, 8'h2D, 2'd1, 0, 0, 0, 1, "sel_01"));
      vecs.push_back(mk(0, 8'h4B, 2'd2, 0, 0, 0, 1, "sel_10"));
      vecs.push_back(mk(0, 8'h87, 2'd3, 0, 0, 0, 1, "sel_11"));
      // Walking one and walking zero.
      for (int i = 0; i < 4; i++) begin
         d = 8'h00;
         d[i] = 1'b1;
         d[4+i] = 1'b1;
         vecs.push_back(mk(0, d, 2'(i), 0, 0, 1, 1, $sformatf("walk1_s%0d", i)));
         vecs.push_back(mk(0, ~d, 2'(i), 0, 0, 0, 0, $sformatf("walk0_s%0d", i)));
      end
      // Enables.
      vecs.push_back(mk(0, 8'h11, 2'd0, 1, 0, 0, 1, "en_e1_off"));
      vecs.push_back(mk(0, 8'h11, 2'd0, 0, 1, 1, 0, "en_e2_off"));
      vecs.push_back(mk(0, 8'h11, 2'd0, 1, 1, 0, 0, "en_both_off"));
      vecs.push_back(mk(0, 8'hFF, 2'd3, 1, 1, 0, 0, "en_both_off_ones"));
      // X on the unselected inputs must not reach the outputs.
      vecs.push_back(mk(0, 8'bxxx1_xxx0, 2'd0, 0, 0, 0, 1, "x_unsel_s0"));
      vecs.push_back(mk(0, 8'b1xxx_0xxx, 2'd3, 0, 0, 0, 1, "x_unsel_s3"));

      foreach (vecs[i]) apply(vecs[i]);

      // Latency: in0 rises between edges. y1 must hold until the next rising edge.
      apply(mk(0, 8'h00, 2'd0, 0, 0, 0, 0, "lat_setup"));
      @(negedge clk);
      in0 = 1'b1;
      #2;
      check("lat_hold_between_edges", y1, y2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("lat_after_edge", y1, y2, 1'b1, 1'b0);

      // Reset in mid-operation for one edge.
      apply(mk(0, 8'hFF, 2'd1, 0, 0, 1, 1, "midrst_steady1"));
      apply(mk(0, 8'hFF, 2'd1, 0, 0, 1, 1, "midrst_steady2"));
      apply(mk(1, 8'hFF, 2'd1, 0, 0, 0, 0, "midrst_assert"));
      apply(mk(0, 8'hFF, 2'd1, 0, 0, 1, 1, "midrst_release"));

      // Random vectors checked against a direct index model.
      for (int i = 0; i < 32; i++) begin
         d   = 8'($urandom);
         s   = 2'($urandom_range(0, 3));
         en1 = ($urandom_range(0, 3) == 0);
         en2 = ($urandom_range(0, 3) == 0);
         apply(mk(0, d, s, en1, en2, ~en1 & d[s], ~en2 & d[4+s], $sformatf("rand_%0d", i)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
